seg_display_ctrl: RTL and testbench
===================================

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 Clk  input  1  system clock, 50 MHz; the only clock in the block.
REQ-002 Reset_n  input  1  asynchronous, active-low reset.
REQ-003 Scan_clk  input  1  100 Hz square wave from the clock divider; treated as data, never as a clock.
REQ-004 Result  input  8  ALU result to display.
REQ-005 Is_signed  input  1  1: Result is two's complement; 0: Result is unsigned.
REQ-006 An  output  4  digit anodes, active-low one-hot; An[0] is the ones digit, An[3] is the sign digit.
REQ-007 Seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-008 Busy  output  1  high while a conversion is in progress.

Function
REQ-009 Scan_clk SHALL pass through a 2-flop synchronizer; a rising edge on the synchronized signal SHALL produce scan_tick, one Clk cycle wide.
REQ-010 Scan_clk held constant SHALL produce no scan_tick.
REQ-011 Flag en SHALL set on the first scan_tick.
REQ-012 The 2-bit digit index idx SHALL increment on each scan_tick while en=1, wrapping 3->0, so the first tick selects digit 0.
REQ-013 An SHALL be registered: 4'b1111 while en=0, otherwise ~(1<<idx), lagging idx by one cycle.
REQ-014 Seg SHALL be the registered decode of the digit selected by idx, updated every cycle with one cycle of latency.
REQ-015 Digit codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111, minus=0111111.
REQ-016 Conversion FSM states SHALL be IDLE, LOAD, SHIFT, COMMIT.
REQ-017 IDLE->LOAD when {Is_signed,Result} differs from the last captured pair.
REQ-018 LOAD SHALL capture {Is_signed,Result} and form the magnitude.
REQ-019 Magnitude rule: if Is_signed=1 and Result[7]=1, magnitude = 256-Result, a 9-bit value (8'h80 gives 128); otherwise magnitude = Result.
REQ-020 SHIFT SHALL run exactly 8 double-dabble iterations, one per cycle, adding 3 to each BCD nibble >= 5 before each shift.
REQ-021 COMMIT SHALL update the hundreds, tens, ones and negative display registers simultaneously, then return to IDLE.
REQ-022 The display registers SHALL be updated on the edge ending COMMIT, 10 cycles after the IDLE cycle that detected the mismatch.
REQ-023 Busy SHALL be 1 in LOAD, SHIFT and COMMIT, and 0 in IDLE.
REQ-024 Input changes during a conversion SHALL NOT affect that conversion; they are compared again in the first IDLE cycle after it.
REQ-025 Digit 2 SHALL be blank when hundreds=0.
REQ-026 Digit 1 SHALL be blank when hundreds=0 and tens=0.
REQ-027 Digit 0 SHALL always be shown.
REQ-028 Digit 3 SHALL show minus when negative=1, otherwise blank.
REQ-029 A scan_tick coinciding with COMMIT SHALL advance idx normally; Seg SHALL show the new digit values one cycle later without glitching through other codes.

Reset
REQ-030 Reset_n=0 SHALL immediately force: FSM=IDLE, Busy=0, en=0, idx=0, An=4'b1111, Seg=7'b1111111, synchronizer flops=0.
REQ-031 Reset SHALL clear the captured pair to {0,8'h00} and the display registers to hundreds=0, tens=0, ones=0, negative=0.
REQ-032 Reset asserted mid-conversion SHALL abandon the conversion; the display registers SHALL NOT be updated.

Structure
REQ-033 Shared package seg_pkg SHALL hold the FSM state enum, the segment code constants (REQ-015) and the digit-to-segment decode function.
REQ-034 The conversion FSM SHALL be one sub-module, bin2bcd_seq (start, 9-bit magnitude in; BCD digits, done, busy out).
REQ-035 Scan, blanking and output logic SHALL stay in seg_display_ctrl.

Verification
REQ-036 Reset release with Result=0, Is_signed=0, then 4 scan_ticks -> An 1110,1101,1011,0111; Seg 1000000, blank, blank, blank; Busy stays 0.
REQ-037 Result=8'd255, Is_signed=0 -> Busy high for exactly 10 cycles; digits 0..3 = 5, 5, 2, blank.
REQ-038 Result=8'h80, Is_signed=1 -> display reads "-128"; digit 3 Seg=0111111. Result=8'hFF, Is_signed=1 -> "-  1".
REQ-039 Result=8'd7 -> digits 1 and 2 blank. Result=8'd105 -> digit 1 shows 0 (Seg 1000000).
REQ-040 Result changes 12->34 on the 4th SHIFT cycle -> 12 commits first, then the second conversion starts in the next IDLE cycle; 34 commits 10 cycles later.
REQ-041 Reset_n pulsed low mid-SHIFT with Scan_clk running -> outputs take reset values within the same cycle; after release, 0 is displayed and the first tick selects digit 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types for the 7-segment display controller: conversion FSM states,
// active-low segment codes and the symbol-to-segment decode.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } conv_state_t;

    // Segment bit order is {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    // Symbols 0..9 are decimal digits; two extra codes for blank and minus.
    localparam logic [3:0] SYM_BLANK = 4'd10;
    localparam logic [3:0] SYM_MINUS = 4'd11;

    function automatic logic [6:0] seg_decode(input logic [3:0] sym);
        case (sym)
            4'd0:      return SEG_0;
            4'd1:      return SEG_1;
            4'd2:      return SEG_2;
            4'd3:      return SEG_3;
            4'd4:      return SEG_4;
            4'd5:      return SEG_5;
            4'd6:      return SEG_6;
            4'd7:      return SEG_7;
            4'd8:      return SEG_8;
            4'd9:      return SEG_9;
            SYM_MINUS: return SEG_MINUS;
            default:   return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 9-bit magnitude to three BCD digits.
// Latency: start seen in IDLE -> LOAD, 8 SHIFT, COMMIT (done); start is ignored while busy.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [8:0] magnitude,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       done,
    output logic       busy,
    output logic       load
);

    conv_state_t state, state_nxt;
    logic [11:0] bcd;
    logic [11:0] bcd_adj;
    logic [7:0]  bin;
    logic [2:0]  cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                load      = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt == 3'd7) state_nxt = COMMIT;
            end
            COMMIT: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // The MSB is pre-shifted into the ones nibble at load (no adjust can apply to
    // a zero BCD field), so 8 iterations cover all 9 magnitude bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd <= '0;
            bin <= '0;
            cnt <= '0;
        end else begin
            case (state)
                LOAD: begin
                    bcd <= {11'd0, magnitude[8]};
                    bin <= magnitude[7:0];
                    cnt <= '0;
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    cnt        <= cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign hundreds = bcd[11:8];
    assign tens     = bcd[7:4];
    assign ones     = bcd[3:0];

endmodule

// File: rtl/seg_display_ctrl.sv
// Four-digit multiplexed signed/unsigned display of an 8-bit result.
// Latency: An/Seg registered one cycle after idx; new value shown 11 cycles after input change; no backpressure.
module seg_display_ctrl
    import seg_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Scan_clk,
    input  logic [7:0] Result,
    input  logic       Is_signed,
    output logic [3:0] An,
    output logic [6:0] Seg,
    output logic       Busy
);

    logic       scan_meta, scan_sync, scan_prev;
    logic       scan_tick;
    logic       en;
    logic [1:0] idx;

    logic       cap_signed;
    logic [7:0] cap_result;
    logic       start;
    logic [8:0] magnitude;

    logic       conv_load, conv_done;
    logic [3:0] bcd_h, bcd_t, bcd_o;
    logic [3:0] disp_h, disp_t, disp_o;
    logic       disp_neg;
    logic [3:0] sym;

    // Scan_clk is asynchronous data; only its synchronized rising edge is used.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            scan_meta <= 1'b0;
            scan_sync <= 1'b0;
            scan_prev <= 1'b0;
        end else begin
            scan_meta <= Scan_clk;
            scan_sync <= scan_meta;
            scan_prev <= scan_sync;
        end
    end

    assign scan_tick = scan_sync & ~scan_prev;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            en  <= 1'b0;
            idx <= 2'd0;
        end else if (scan_tick) begin
            en <= 1'b1;
            if (en) idx <= idx + 2'd1;
        end
    end

    assign start     = {Is_signed, Result} != {cap_signed, cap_result};
    assign magnitude = (Is_signed && Result[7]) ? 9'd256 - {1'b0, Result} : {1'b0, Result};

    bin2bcd_seq u_bin2bcd (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .start     (start),
        .magnitude (magnitude),
        .hundreds  (bcd_h),
        .tens      (bcd_t),
        .ones      (bcd_o),
        .done      (conv_done),
        .busy      (Busy),
        .load      (conv_load)
    );

    // The captured pair and the magnitude are sampled on the same LOAD edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cap_signed <= 1'b0;
            cap_result <= 8'h00;
            disp_h     <= 4'd0;
            disp_t     <= 4'd0;
            disp_o     <= 4'd0;
            disp_neg   <= 1'b0;
        end else begin
            if (conv_load) begin
                cap_signed <= Is_signed;
                cap_result <= Result;
            end
            if (conv_done) begin
                disp_h   <= bcd_h;
                disp_t   <= bcd_t;
                disp_o   <= bcd_o;
                disp_neg <= cap_signed & cap_result[7];
            end
        end
    end

    always_comb begin
        sym = SYM_BLANK;
        case (idx)
            2'd0: sym = disp_o;
            2'd1: if (disp_h != 4'd0 || disp_t != 4'd0) sym = disp_t;
            2'd2: if (disp_h != 4'd0) sym = disp_h;
            2'd3: if (disp_neg) sym = SYM_MINUS;
            default: sym = SYM_BLANK;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            An  <= 4'b1111;
            Seg <= SEG_BLANK;
        end else begin
            An  <= en ? ~(4'b0001 << idx) : 4'b1111;
            Seg <= seg_decode(sym);
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl against an arithmetic display model.
module tb_seg_display_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Scan_clk;
    logic [7:0] Result;
    logic       Is_signed;
    logic [3:0] An;
    logic [6:0] Seg;
    logic       Busy;

    int pass_cnt   = 0;
    int total_cnt  = 0;
    int tick_count = 0;
    int busy_lat;
    int busy_len;
    logic [7:0] last_r;
    logic       last_s;

    logic [3:0] obs_an    [4];
    logic [6:0] obs_seg   [4];
    int         obs_digit [4];

    seg_display_ctrl dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Scan_clk  (Scan_clk),
        .Result    (Result),
        .Is_signed (Is_signed),
        .An        (An),
        .Seg       (Seg),
        .Busy      (Busy)
    );

    always #10 Clk = ~Clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] digit_code(input int n);
        case (n)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected segments of display position d for input pair (r, s).
    function automatic logic [6:0] exp_seg(input int d, input logic [7:0] r, input logic s);
        int v, m, h, t, o;
        v = s ? int'($signed(r)) : int'(r);
        m = (v < 0) ? -v : v;
        h = m / 100;
        t = (m / 10) % 10;
        o = m % 10;
        case (d)
            0: return digit_code(o);
            1: return (h == 0 && t == 0) ? 7'b1111111 : digit_code(t);
            2: return (h == 0) ? 7'b1111111 : digit_code(h);
            default: return (v < 0) ? 7'b0111111 : 7'b1111111;
        endcase
    endfunction

    task automatic do_tick();
        @(negedge Clk); Scan_clk = 1'b1;
        repeat (4) @(negedge Clk);
        Scan_clk = 1'b0;
        repeat (3) @(negedge Clk);
        tick_count++;
    endtask

    task automatic scan_collect(input int n);
        for (int k = 0; k < n; k++) begin
            do_tick();
            obs_an[k]    = An;
            obs_seg[k]   = Seg;
            obs_digit[k] = (tick_count - 1) % 4;
        end
    endtask

    task automatic run_conversion(input logic [7:0] r, input logic s);
        @(negedge Clk);
        Result = r; Is_signed = s; last_r = r; last_s = s;
        busy_lat = -1;
        busy_len = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge Clk);
            if (Busy === 1'b1) begin busy_lat = i; break; end
        end
        if (busy_lat > 0) begin
            busy_len = 1;
            for (int i = 0; i < 40; i++) begin
                @(negedge Clk);
                if (Busy !== 1'b1) break;
                busy_len++;
            end
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Scan_clk = 1'b0; Result = 8'd0; Is_signed = 1'b0;
        last_r = 8'd0; last_s = 1'b0;
        repeat (3) @(negedge Clk);
        total_cnt++; if (An !== 4'b1111) $display("FAIL reset_an: got %b expected 1111", An); else pass_cnt++;
        total_cnt++; if (Seg !== 7'b1111111) $display("FAIL reset_seg: got %b expected 1111111", Seg); else pass_cnt++;
        total_cnt++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", Busy); else pass_cnt++;
        Reset_n = 1'b1;
        tick_count = 0;
        repeat (12) @(negedge Clk);
        total_cnt++; if (Busy !== 1'b0) $display("FAIL post_reset_busy: got %b expected 0", Busy); else pass_cnt++;
        total_cnt++; if (An !== 4'b1111) $display("FAIL post_reset_an: got %b expected 1111", An); else pass_cnt++;
        total_cnt++; if (Seg !== 7'b1000000) $display("FAIL post_reset_seg: got %b expected 1000000", Seg); else pass_cnt++;
    endtask

    task automatic test_scan_idle();
        logic [3:0] exp_an [3];
        exp_an = '{4'b1101, 4'b1011, 4'b0111};
        @(negedge Clk); Scan_clk = 1'b1;
        repeat (3) @(negedge Clk);
        total_cnt++; if (An !== 4'b1111) $display("FAIL first_tick_an_early: got %b expected 1111", An); else pass_cnt++;
        @(negedge Clk);
        total_cnt++; if (An !== 4'b1110) $display("FAIL first_tick_an: got %b expected 1110", An); else pass_cnt++;
        total_cnt++; if (Seg !== 7'b1000000) $display("FAIL first_tick_seg: got %b expected 1000000", Seg); else pass_cnt++;
        Scan_clk = 1'b0;
        tick_count = 1;
        repeat (3) @(negedge Clk);
        scan_collect(3);
        for (int k = 0; k < 3; k++) begin
            total_cnt++; if (obs_an[k] !== exp_an[k]) $display("FAIL idle_scan_an%0d: got %b expected %b", k + 1, obs_an[k], exp_an[k]); else pass_cnt++;
            total_cnt++; if (obs_seg[k] !== 7'b1111111) $display("FAIL idle_scan_seg%0d: got %b expected 1111111", k + 1, obs_seg[k]); else pass_cnt++;
        end
        total_cnt++; if (Busy !== 1'b0) $display("FAIL idle_scan_busy: got %b expected 0", Busy); else pass_cnt++;
    endtask

    task automatic test_conv_255();
        logic [3:0] ea;
        logic [6:0] es;
        run_conversion(8'd255, 1'b0);
        total_cnt++; if (busy_lat !== 1) $display("FAIL c255_busy_latency: got %0d expected 1", busy_lat); else pass_cnt++;
        total_cnt++; if (busy_len !== 10) $display("FAIL c255_busy_cycles: got %0d expected 10", busy_len); else pass_cnt++;
        scan_collect(4);
        for (int k = 0; k < 4; k++) begin
            ea = ~(4'b0001 << obs_digit[k]);
            es = exp_seg(obs_digit[k], 8'd255, 1'b0);
            total_cnt++; if (obs_an[k] !== ea) $display("FAIL c255_an_d%0d: got %b expected %b", obs_digit[k], obs_an[k], ea); else pass_cnt++;
            total_cnt++; if (obs_seg[k] !== es) $display("FAIL c255_seg_d%0d: got %b expected %b", obs_digit[k], obs_seg[k], es); else pass_cnt++;
        end
    endtask

    task automatic test_signed();
        logic [7:0] rv [2];
        logic [6:0] es;
        rv = '{8'h80, 8'hFF};
        for (int j = 0; j < 2; j++) begin
            run_conversion(rv[j], 1'b1);
            total_cnt++; if (busy_len !== 10) $display("FAIL signed_%0h_busy_cycles: got %0d expected 10", rv[j], busy_len); else pass_cnt++;
            scan_collect(4);
            for (int k = 0; k < 4; k++) begin
                es = exp_seg(obs_digit[k], rv[j], 1'b1);
                total_cnt++; if (obs_seg[k] !== es) $display("FAIL signed_%0h_seg_d%0d: got %b expected %b", rv[j], obs_digit[k], obs_seg[k], es); else pass_cnt++;
            end
        end
    endtask

    task automatic test_blanking();
        logic [7:0] rv [2];
        logic [6:0] es;
        rv = '{8'd7, 8'd105};
        for (int j = 0; j < 2; j++) begin
            run_conversion(rv[j], 1'b0);
            scan_collect(4);
            for (int k = 0; k < 4; k++) begin
                es = exp_seg(obs_digit[k], rv[j], 1'b0);
                total_cnt++; if (obs_seg[k] !== es) $display("FAIL blank_%0d_seg_d%0d: got %b expected %b", rv[j], obs_digit[k], obs_seg[k], es); else pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [25:1] busy_obs, busy_exp;
        logic [6:0]  seg_obs [26];
        logic [6:0]  es;
        while (!(tick_count > 0 && (tick_count - 1) % 4 == 0)) do_tick();
        @(negedge Clk);
        Result = 8'd12; Is_signed = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            @(negedge Clk);
            busy_obs[n] = Busy;
            seg_obs[n]  = Seg;
            busy_exp[n] = (n >= 1 && n <= 10) || (n >= 12 && n <= 21);
            if (n == 5) Result = 8'd34;
        end
        last_r = 8'd34; last_s = 1'b0;
        total_cnt++; if (busy_obs !== busy_exp) $display("FAIL b2b_busy_pattern: got %b expected %b", busy_obs, busy_exp); else pass_cnt++;
        es = exp_seg(0, 8'd105, 1'b0);
        total_cnt++; if (seg_obs[11] !== es) $display("FAIL b2b_seg_before_commit: got %b expected %b", seg_obs[11], es); else pass_cnt++;
        es = exp_seg(0, 8'd12, 1'b0);
        total_cnt++; if (seg_obs[12] !== es) $display("FAIL b2b_seg_first_commit: got %b expected %b", seg_obs[12], es); else pass_cnt++;
        total_cnt++; if (seg_obs[22] !== es) $display("FAIL b2b_seg_hold_first: got %b expected %b", seg_obs[22], es); else pass_cnt++;
        es = exp_seg(0, 8'd34, 1'b0);
        total_cnt++; if (seg_obs[23] !== es) $display("FAIL b2b_seg_second_commit: got %b expected %b", seg_obs[23], es); else pass_cnt++;
        scan_collect(4);
        for (int k = 0; k < 4; k++) begin
            es = exp_seg(obs_digit[k], 8'd34, 1'b0);
            total_cnt++; if (obs_seg[k] !== es) $display("FAIL b2b_final_seg_d%0d: got %b expected %b", obs_digit[k], obs_seg[k], es); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        logic       s;
        logic [3:0] ea;
        logic [6:0] es;
        for (int j = 0; j < 6; j++) begin
            do begin
                r = 8'($urandom);
                s = 1'($urandom);
            end while ({s, r} == {last_s, last_r} || {s, r} == 9'h1C8);
            run_conversion(r, s);
            total_cnt++; if (busy_lat !== 1 || busy_len !== 10) $display("FAIL rand_%0d_busy: got lat %0d len %0d expected lat 1 len 10", j, busy_lat, busy_len); else pass_cnt++;
            scan_collect(4);
            for (int k = 0; k < 4; k++) begin
                ea = ~(4'b0001 << obs_digit[k]);
                es = exp_seg(obs_digit[k], r, s);
                total_cnt++; if (obs_an[k] !== ea) $display("FAIL rand_%0d_an_d%0d: got %b expected %b", j, obs_digit[k], obs_an[k], ea); else pass_cnt++;
                total_cnt++; if (obs_seg[k] !== es) $display("FAIL rand_%0d_seg_d%0d r=%0h s=%0b: got %b expected %b", j, obs_digit[k], r, s, obs_seg[k], es); else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] es;
        @(negedge Clk);
        Result = 8'hC8; Is_signed = 1'b1; last_r = 8'hC8; last_s = 1'b1;
        repeat (2) @(negedge Clk);
        Scan_clk = 1'b1;
        repeat (2) @(negedge Clk);
        total_cnt++; if (Busy !== 1'b1) $display("FAIL mid_busy_before_reset: got %b expected 1", Busy); else pass_cnt++;
        #3 Reset_n = 1'b0;
        #1;
        total_cnt++; if (An !== 4'b1111) $display("FAIL mid_reset_an: got %b expected 1111", An); else pass_cnt++;
        total_cnt++; if (Seg !== 7'b1111111) $display("FAIL mid_reset_seg: got %b expected 1111111", Seg); else pass_cnt++;
        total_cnt++; if (Busy !== 1'b0) $display("FAIL mid_reset_busy: got %b expected 0", Busy); else pass_cnt++;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        tick_count = 0;
        @(negedge Clk);
        total_cnt++; if (Busy !== 1'b1) $display("FAIL mid_restart_busy: got %b expected 1", Busy); else pass_cnt++;
        repeat (2) @(negedge Clk);
        total_cnt++; if (An !== 4'b1111) $display("FAIL mid_release_an_early: got %b expected 1111", An); else pass_cnt++;
        @(negedge Clk);
        total_cnt++; if (An !== 4'b1110) $display("FAIL mid_release_an: got %b expected 1110", An); else pass_cnt++;
        total_cnt++; if (Seg !== 7'b1000000) $display("FAIL mid_release_seg: got %b expected 1000000", Seg); else pass_cnt++;
        Scan_clk = 1'b0;
        tick_count = 1;
        repeat (12) @(negedge Clk);
        total_cnt++; if (Busy !== 1'b0) $display("FAIL mid_final_busy: got %b expected 0", Busy); else pass_cnt++;
        scan_collect(4);
        for (int k = 0; k < 4; k++) begin
            es = exp_seg(obs_digit[k], 8'hC8, 1'b1);
            total_cnt++; if (obs_seg[k] !== es) $display("FAIL mid_final_seg_d%0d: got %b expected %b", obs_digit[k], obs_seg[k], es); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_scan_idle();
        test_conv_255();
        test_signed();
        test_blanking();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
